// File: rtl/dmem_lsu_if.sv
// Load/store bus between the EX/MEM stage and the data memory.
// Optional macro DMEM_RANGE_CHK_EN adds the AccessFault_o return signal.
interface dmem_lsu_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] Address_i;
  logic [31:0]       WriteData_i;
  logic              ReadEn_i;
  logic              WriteEn_i;
  logic [2:0]        Funct3_i;
  logic [31:0]       Data_o;
  logic              DataValid_o;
  logic              Misaligned_o;
`ifdef DMEM_RANGE_CHK_EN
  logic              AccessFault_o;

  modport master (
    output Address_i, WriteData_i, ReadEn_i, WriteEn_i, Funct3_i,
    input  Data_o, DataValid_o, Misaligned_o, AccessFault_o
  );
  modport slave (
    input  Address_i, WriteData_i, ReadEn_i, WriteEn_i, Funct3_i,
    output Data_o, DataValid_o, Misaligned_o, AccessFault_o
  );
`else
  modport master (
    output Address_i, WriteData_i, ReadEn_i, WriteEn_i, Funct3_i,
    input  Data_o, DataValid_o, Misaligned_o
  );
  modport slave (
    input  Address_i, WriteData_i, ReadEn_i, WriteEn_i, Funct3_i,
    output Data_o, DataValid_o, Misaligned_o
  );
`endif
endinterface

// File: rtl/dmem_lsu.sv
// Byte-addressable data memory with RV32I load/store sizing, misalignment
// detection and a 1- or 2-cycle read pipeline.
// Optional macro DMEM_RANGE_CHK_EN: flag accesses past the end of the array
// instead of wrapping, and suppress their effect.
module dmem_lsu #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int RD_LAT      = 1
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_BYTES);
  typedef logic [IDX_W-1:0] idx_t;

  logic [7:0] mem [DEPTH_BYTES];

  idx_t idx0, idx1, idx2, idx3;
  logic [1:0] size;
  logic sizeMis, reqLoadMis, rangeFault, storeOk;

  // Byte lanes are little-endian and wrap modulo the array size.
  assign idx0 = bus.Address_i[IDX_W-1:0];
  assign idx1 = idx0 + idx_t'(1);
  assign idx2 = idx0 + idx_t'(2);
  assign idx3 = idx0 + idx_t'(3);
  assign size = bus.Funct3_i[1:0];

  // Size 11 is illegal; halves need even, words need 4-byte alignment.
  always_comb begin
    sizeMis = 1'b0;
    case (size)
      2'b01:   sizeMis = bus.Address_i[0];
      2'b10:   sizeMis = (bus.Address_i[1:0] != 2'b00);
      2'b11:   sizeMis = 1'b1;
      default: sizeMis = 1'b0;
    endcase
  end

  // Loads additionally treat funct3 110/111 as illegal.
  assign reqLoadMis = sizeMis | (bus.Funct3_i[2] & bus.Funct3_i[1]);

`ifdef DMEM_RANGE_CHK_EN
  logic [1:0]      lastOff;
  logic [ADDR_W:0] lastByte;
  assign lastOff    = (size == 2'b00) ? 2'd0 : (size == 2'b01) ? 2'd1 : 2'd3;
  assign lastByte   = {1'b0, bus.Address_i} + {{(ADDR_W-1){1'b0}}, lastOff};
  assign rangeFault = (lastByte > (ADDR_W+1)'(DEPTH_BYTES - 1));
`else
  logic unusedAddrBits;
  assign unusedAddrBits = ^bus.Address_i[ADDR_W-1:IDX_W];
  assign rangeFault     = 1'b0;
`endif

  assign storeOk = bus.WriteEn_i & ~rst & ~sizeMis & ~rangeFault;

  // Store path: writes only the lanes covered by the access size.
  always_ff @(posedge clk) begin
    if (storeOk) begin
      mem[idx0] <= bus.WriteData_i[7:0];
      if (size != 2'b00) mem[idx1] <= bus.WriteData_i[15:8];
      if (size == 2'b10) begin
        mem[idx2] <= bus.WriteData_i[23:16];
        mem[idx3] <= bus.WriteData_i[31:24];
      end
    end
  end

  logic        s1Valid, s1Mis, s1Fault;
  logic [31:0] s1Raw;
  logic [2:0]  s1Funct3;

  // Stage 1 captures the raw word; reading here before the store lands
  // gives read-before-write when a load and store share a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid  <= 1'b0;
      s1Raw    <= '0;
      s1Funct3 <= '0;
      s1Mis    <= 1'b0;
      s1Fault  <= 1'b0;
    end else begin
      s1Valid <= bus.ReadEn_i;
      if (bus.ReadEn_i) begin
        s1Raw    <= {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
        s1Funct3 <= bus.Funct3_i;
        s1Mis    <= reqLoadMis;
        s1Fault  <= rangeFault;
      end
    end
  end

  logic [31:0] extData;

  // Extract and extend the addressed byte/half/word; faulting loads read zero.
  always_comb begin
    extData = '0;
    if (!s1Mis && !s1Fault) begin
      case (s1Funct3)
        3'b000:  extData = {{24{s1Raw[7]}}, s1Raw[7:0]};
        3'b001:  extData = {{16{s1Raw[15]}}, s1Raw[15:0]};
        3'b010:  extData = s1Raw;
        3'b100:  extData = {24'd0, s1Raw[7:0]};
        3'b101:  extData = {16'd0, s1Raw[15:0]};
        default: extData = '0;
      endcase
    end
  end

  logic        outValid, outMis, outFault;
  logic [31:0] outData;

  if (RD_LAT == 1) begin : gLat1
    assign outValid = s1Valid;
    assign outData  = extData;
    assign outMis   = s1Valid & s1Mis;
    assign outFault = s1Valid & s1Fault;
  end else begin : gLat2
    logic        s2Valid, s2Mis, s2Fault;
    logic [31:0] s2Data;

    // Second stage re-registers the extended result; data holds between loads.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2Valid <= 1'b0;
        s2Mis   <= 1'b0;
        s2Fault <= 1'b0;
        s2Data  <= '0;
      end else begin
        s2Valid <= s1Valid;
        s2Mis   <= s1Valid & s1Mis;
        s2Fault <= s1Valid & s1Fault;
        if (s1Valid) s2Data <= extData;
      end
    end

    assign outValid = s2Valid;
    assign outData  = s2Data;
    assign outMis   = s2Mis;
    assign outFault = s2Fault;
  end

  assign bus.Data_o       = outData;
  assign bus.DataValid_o  = outValid;
  assign bus.Misaligned_o = outMis | (bus.WriteEn_i & ~rst & sizeMis);
`ifdef DMEM_RANGE_CHK_EN
  assign bus.AccessFault_o = outFault | (bus.WriteEn_i & ~rst & rangeFault);
`else
  logic unusedFault;
  assign unusedFault = outFault;
`endif
endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: one instance at each read latency, driven
// by identical stimulus and checked against a byte-array reference model.
module tb_dmem_lsu;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
    logic        fault;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_lsu_if #(.ADDR_W(ADDR_W)) bus1 ();
  dmem_lsu_if #(.ADDR_W(ADDR_W)) bus2 ();

  dmem_lsu #(.DEPTH_BYTES(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dmem_lsu #(.DEPTH_BYTES(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic flt1, flt2;
`ifdef DMEM_RANGE_CHK_EN
  assign flt1 = bus1.AccessFault_o;
  assign flt2 = bus2.AccessFault_o;
`else
  assign flt1 = 1'b0;
  assign flt2 = 1'b0;
`endif

  logic [7:0]  modelMem [DEPTH];
  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] lastD [2];
  logic        expStoreMis   = 1'b0;
  logic        expStoreFault = 1'b0;
  bit          monOn = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // ---------------- reference model ----------------
  function automatic int nBytes(logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit misModel(logic [31:0] a, logic [2:0] f3, bit isLoad);
    bit illegal = (f3[1:0] == 2'b11) || (isLoad && (f3 == 3'd6 || f3 == 3'd7));
    return illegal || ((longint'(a) % nBytes(f3)) != 0);
  endfunction

  function automatic bit faultModel(logic [31:0] a, logic [2:0] f3);
`ifdef DMEM_RANGE_CHK_EN
    return (longint'(a) + nBytes(f3) - 1) >= DEPTH;
`else
    return (a == 32'hFFFF_FFFF) && (f3 == 3'd7) && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] loadModel(logic [31:0] a, logic [2:0] f3);
    longint w = 0;
    int b;
    if (misModel(a, f3, 1'b1) || faultModel(a, f3)) return 32'd0;
    for (int k = 0; k < 4; k++)
      w += longint'(modelMem[int'((longint'(a) + k) % DEPTH)]) * (longint'(1) << (8 * k));
    case (f3)
      3'd0: begin b = int'(w % 256);   if (b >= 128)   b -= 256;   return 32'(b); end
      3'd1: begin b = int'(w % 65536); if (b >= 32768) b -= 65536; return 32'(b); end
      3'd2: return 32'(w);
      3'd4: return 32'(w % 256);
      default: return 32'(w % 65536);
    endcase
  endfunction

  function automatic void storeModel(logic [31:0] a, logic [2:0] f3, logic [31:0] wd);
    for (int k = 0; k < nBytes(f3); k++)
      modelMem[int'((longint'(a) + k) % DEPTH)] = 8'((wd >> (8 * k)) & 32'hFF);
  endfunction

  function automatic int qSize(int w);
    return (w == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t qFront(int w);
    return (w == 0) ? sb0[0] : sb1[0];
  endfunction

  function automatic exp_t qPop(int w);
    return (w == 0) ? sb0.pop_front() : sb1.pop_front();
  endfunction

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic re, input logic we, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd, input logic r);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r;
    bus1.ReadEn_i = re;  bus1.WriteEn_i = we;  bus1.Funct3_i = f3;
    bus1.Address_i = a;  bus1.WriteData_i = wd;
    bus2.ReadEn_i = re;  bus2.WriteEn_i = we;  bus2.Funct3_i = f3;
    bus2.Address_i = a;  bus2.WriteData_i = wd;
    if (r) begin
      while (sb0.size() > 0 && sb0[$].due > cyc) void'(sb0.pop_back());
      while (sb1.size() > 0 && sb1[$].due > cyc) void'(sb1.pop_back());
    end else if (re) begin
      e.data  = loadModel(a, f3);
      e.mis   = misModel(a, f3, 1'b1);
      e.fault = faultModel(a, f3);
      e.due   = cyc + 1;
      sb0.push_back(e);
      e.due   = cyc + 2;
      sb1.push_back(e);
    end
    expStoreMis   = we && !r && misModel(a, f3, 1'b0);
    expStoreFault = we && !r && faultModel(a, f3);
    if (we && !r && !misModel(a, f3, 1'b0) && !faultModel(a, f3)) storeModel(a, f3, wd);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    applyStimulus(1'b0, 1'b1, f3, a, wd, 1'b0);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a);
    applyStimulus(1'b1, 1'b0, f3, a, 32'd0, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // ---------------- checking ----------------
  task automatic cmp(input string dutName, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got %h expected %h (cycle %0d)", dutName, nm, act, exp, cyc);
    end
  endtask

  task automatic checkOutput(input int which, input logic v, input logic [31:0] d,
                             input logic m, input logic f);
    exp_t e;
    string nm = (which == 0) ? "lat1" : "lat2";
    if (v) begin
      if (qSize(which) == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s unexpectedValid: got valid with data %h expected none (cycle %0d)", nm, d, cyc);
      end else begin
        e = qPop(which);
        cmp(nm, "latency", 32'(cyc), 32'(e.due));
        cmp(nm, "data", d, e.data);
        cmp(nm, "misaligned", {31'd0, m}, {31'd0, e.mis | expStoreMis});
        cmp(nm, "fault", {31'd0, f}, {31'd0, e.fault | expStoreFault});
        lastD[which] = e.data;
      end
    end else begin
      cmp(nm, "idleMisaligned", {31'd0, m}, {31'd0, expStoreMis});
      cmp(nm, "idleFault", {31'd0, f}, {31'd0, expStoreFault});
      cmp(nm, "holdData", d, lastD[which]);
      if (qSize(which) > 0 && qFront(which).due <= cyc) begin
        e = qPop(which);
        checks++;
        errors++;
        $display("[TB] FAIL %s missingValid: got no valid expected data %h (cycle %0d)", nm, e.data, cyc);
      end
    end
  endtask

  // Cycle counter; a reset edge clears the held output data.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      lastD[0] = 32'd0;
      lastD[1] = 32'd0;
    end
  end

  // Monitor samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (monOn) begin
      checkOutput(0, bus1.DataValid_o, bus1.Data_o, bus1.Misaligned_o, flt1);
      checkOutput(1, bus2.DataValid_o, bus2.Data_o, bus2.Misaligned_o, flt2);
    end
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    logic        re, we, r;
    lastD[0] = 32'd0;
    lastD[1] = 32'd0;
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 8'd0;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    idle();
    monOn = 1'b1;

    for (int i = 0; i < 'h90; i += 4) st(3'd2, 32'(i), $urandom());
    for (int i = 'h3F0; i < 'h400; i += 4) st(3'd2, 32'(i), $urandom());
    st(3'd2, 32'h30, 32'h1111_1111);

    st(3'd2, 32'h10, 32'hDEAD_BEEF);
    ld(3'd2, 32'h10);
    ld(3'd0, 32'h13);
    ld(3'd4, 32'h13);
    ld(3'd1, 32'h12);
    ld(3'd5, 32'h10);
    st(3'd0, 32'h11, 32'h0000_0055);
    ld(3'd2, 32'h10);
    st(3'd1, 32'h12, 32'h0000_1234);
    ld(3'd2, 32'h10);
    st(3'd2, 32'h22, 32'hCAFE_F00D);
    ld(3'd2, 32'h20);
    ld(3'd1, 32'h21);
    ld(3'd6, 32'h20);
    applyStimulus(1'b1, 1'b1, 3'd2, 32'h30, 32'hAAAA_AAAA, 1'b0);
    ld(3'd2, 32'h30);

    ld(3'd2, 32'h10);
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    idle();
    ld(3'd2, 32'h10);

    st(3'd2, 32'h3FE, 32'h5A5A_5A5A);
    st(3'd0, 32'h3FF, 32'h0000_0077);
    ld(3'd2, 32'h400);
    ld(3'd2, 32'h3FC);
    ld(3'd1, 32'h3FE);
    st(3'd2, 32'h0000_0440, 32'h0BAD_CAFE);
    ld(3'd2, 32'h40);

    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      re = !r && ($urandom_range(0, 2) != 0);
      we = !r && ($urandom_range(0, 2) == 0);
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 'h7F));
        1:       a = 32'($urandom_range('h3F8, 'h403));
        default: a = 32'($urandom_range(0, 'h7F));
      endcase
      applyStimulus(re, we, f3, a, $urandom(), r);
    end

    repeat (6) idle();
    cmp("both", "drained", 32'(sb0.size() + sb1.size()), 32'd0);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
